// File: rtl/cmp_arb_pkg.sv
// ============================================================================
// Module   : cmp_arb_pkg
// Brief    : Shared types and constants for the compare-datapath arbiter.
//            Branch funct3 encodings, FSM state encoding and requester limit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmp_arb_pkg;

   localparam int NREQ_MAX = 4;

   // RV32I branch funct3 encodings; 010/011 are not branches
   typedef enum logic [2:0] {
      F3_BEQ  = 3'b000,
      F3_BNE  = 3'b001,
      F3_BLT  = 3'b100,
      F3_BGE  = 3'b101,
      F3_BLTU = 3'b110,
      F3_BGEU = 3'b111
   } f3_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMP  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Ops 11x compare unsigned, everything else reports the signed result
   function automatic logic f3_is_unsigned(input logic [2:0] op);
      return (op[2:1] == 2'b11);
   endfunction

endpackage

`default_nettype wire

// File: rtl/cmp_mag32.sv
// ============================================================================
// Module   : cmp_mag32
// Brief    : 32-bit magnitude comparator, signed or unsigned by parameter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_mag32 #(
   parameter bit SIGNED = 1'b0
) (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic        o_lt
);

   if (SIGNED) begin : g_signed
      assign o_lt = ($signed(i_a) < $signed(i_b));
   end else begin : g_unsigned
      assign o_lt = (i_a < i_b);
   end

endmodule

`default_nettype wire

// File: rtl/cmp_rr_picker.sv
// ============================================================================
// Module   : cmp_rr_picker
// Brief    : Combinational requester picker. Round-robin search starting at
//            i_ptr; with CMP_ARB_FIXED_PRIO_EN defined the lowest valid index
//            wins and i_ptr is ignored.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_rr_picker #(
   parameter  int NREQ = 2,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_valid,
   input  logic [IW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [IW-1:0]   o_idx,
   output logic            o_any
);

`ifdef CMP_ARB_FIXED_PRIO_EN
   // Lowest valid index wins
   always_comb begin : p_pick
      o_any = 1'b0;
      o_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!o_any && i_valid[i]) begin
            o_any = 1'b1;
            o_idx = IW'(i);
         end
      end
      o_grant = o_any ? (NREQ'(1) << o_idx) : '0;
   end
`else
   localparam logic [IW:0] C_NREQ = (IW+1)'(NREQ);

   // Search from the pointer, wrapping modulo NREQ; first valid wins
   always_comb begin : p_pick
      logic [IW:0] cand;
      cand  = '0;
      o_any = 1'b0;
      o_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = {1'b0, i_ptr} + (IW+1)'(i);
         if (cand >= C_NREQ) begin
            cand = cand - C_NREQ;
         end
         if (!o_any && i_valid[cand[IW-1:0]]) begin
            o_any = 1'b1;
            o_idx = cand[IW-1:0];
         end
      end
      o_grant = o_any ? (NREQ'(1) << o_idx) : '0;
   end
`endif

endmodule

`default_nettype wire

// File: rtl/cmp_share_arb.sv
// ============================================================================
// Module   : cmp_share_arb
// Brief    : Shares one 32-bit signed/unsigned compare datapath among NREQ
//            requesters. IDLE accepts one request, CMP registers the branch
//            result, RESP holds it until the granted requester accepts.
//            Build option CMP_ARB_FIXED_PRIO_EN selects fixed lowest-index
//            priority instead of round-robin (no pointer register then).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_share_arb
   import cmp_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int XLEN = 32
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NREQ-1:0]    i_req_valid,
   output logic [NREQ-1:0]    o_req_ready,
   input  logic [NREQ*XLEN-1:0] i_req_a,
   input  logic [NREQ*XLEN-1:0] i_req_b,
   input  logic [NREQ*3-1:0]  i_req_op,
   output logic [NREQ-1:0]    o_rsp_valid,
   input  logic [NREQ-1:0]    i_rsp_ready,
   output logic               o_rsp_taken,
   output logic               o_rsp_lt,
   output logic               o_rsp_eq,
   output logic               o_busy
);

   localparam int IW = $clog2(NREQ);

   if (XLEN != 32 || NREQ < 2 || NREQ > NREQ_MAX) begin : g_bad_param
      $error("cmp_share_arb: XLEN must be 32 and NREQ in 2..4");
   end

   state_e            state_q, state_d;
   logic [IW-1:0]     grant_q, grant_d;
   logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
   logic [2:0]        op_q, op_d;
   logic              taken_q, taken_d;
   logic              lt_q, lt_d;
   logic              eq_q, eq_d;

   logic [IW-1:0]     ptr;
   logic [NREQ-1:0]   pick_grant;
   logic [IW-1:0]     pick_idx;
   logic              pick_any;
   logic              lt_s, lt_u, eq_w;

   cmp_rr_picker #(.NREQ(NREQ)) u_picker (
      .i_valid (i_req_valid),
      .i_ptr   (ptr),
      .o_grant (pick_grant),
      .o_idx   (pick_idx),
      .o_any   (pick_any)
   );

   cmp_mag32 #(.SIGNED(1'b1)) u_cmp_s (.i_a(a_q), .i_b(b_q), .o_lt(lt_s));
   cmp_mag32 #(.SIGNED(1'b0)) u_cmp_u (.i_a(a_q), .i_b(b_q), .o_lt(lt_u));

   assign eq_w = (a_q == b_q);

`ifdef CMP_ARB_FIXED_PRIO_EN
   assign ptr = '0;
`else
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] grant_next;

   assign grant_next = (grant_q == IW'(NREQ-1)) ? '0 : grant_q + 1'b1;
   assign ptr        = ptr_q;

   // Advance the rotation past the requester whose response just completed
   always_comb begin
      ptr_d = ptr_q;
      if (state_q == ST_RESP && i_rsp_ready[grant_q]) begin
         ptr_d = grant_next;
      end
   end

   // Round-robin pointer register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   // Next-state, operand capture, result computation and handshake outputs
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      taken_d     = taken_q;
      lt_d        = lt_q;
      eq_d        = eq_q;
      o_req_ready = '0;
      o_rsp_valid = '0;
      case (state_q)
         ST_IDLE: begin
            // Ready is gated by reset so nothing is granted while held
            if (pick_any && i_rst_n) begin
               o_req_ready = pick_grant;
               grant_d     = pick_idx;
               a_d         = i_req_a[pick_idx*XLEN +: XLEN];
               b_d         = i_req_b[pick_idx*XLEN +: XLEN];
               op_d        = i_req_op[pick_idx*3 +: 3];
               state_d     = ST_CMP;
            end
         end
         ST_CMP: begin
            case (op_q)
               F3_BEQ:  taken_d = eq_w;
               F3_BNE:  taken_d = ~eq_w;
               F3_BLT:  taken_d = lt_s;
               F3_BGE:  taken_d = ~lt_s;
               F3_BLTU: taken_d = lt_u;
               F3_BGEU: taken_d = ~lt_u;
               default: taken_d = 1'b0;
            endcase
            lt_d    = f3_is_unsigned(op_q) ? lt_u : lt_s;
            eq_d    = eq_w;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            o_rsp_valid[grant_q] = 1'b1;
            if (i_rsp_ready[grant_q]) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, grant, operand and result registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         taken_q <= 1'b0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         taken_q <= taken_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
      end
   end

   assign o_rsp_taken = taken_q;
   assign o_rsp_lt    = lt_q;
   assign o_rsp_eq    = eq_q;
   assign o_busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire
